// File: rtl/down_timer_pkg.sv
// Shared state encodings for the down_timer block.
package down_timer_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/down_timer_prescaler.sv
// Reusable tick prescaler: while enabled, fires one tick every prescale_i+1 cycles.
// prescale_i is used live, so lowering it below the running count ticks at once.
module tick_prescaler #(
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [PW-1:0] prescale_i,
  output logic          tick_o
);

  logic [PW-1:0] pre_cnt_q;
  logic [PW-1:0] pre_cnt_d;

  assign tick_o = en_i & ~clr_i & (pre_cnt_q >= prescale_i);

  // Next prescaler count: clear wins, tick wraps to zero, otherwise advance while enabled.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (clr_i) begin
      pre_cnt_d = '0;
    end else if (tick_o) begin
      pre_cnt_d = '0;
    end else if (en_i) begin
      pre_cnt_d = pre_cnt_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      pre_cnt_d = pre_cnt_q;
    end
  end

  // Prescaler count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/down_timer.sv
// Loadable down-counting timer with prescaler, one-shot and auto-reload modes.
// Control priority each cycle: load > stop > start > tick.
module down_timer
  import down_timer_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic [N-1:0]  load_value_i,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic          auto_reload_i,
  input  logic [PW-1:0] prescale_i,
  output logic [N-1:0]  count_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          tc_pulse_o
);

  state_e       state_q;
  state_e       state_d;
  logic [N-1:0] count_q;
  logic [N-1:0] count_d;
  logic [N-1:0] reload_q;
  logic [N-1:0] reload_d;
  logic         tc_q;
  logic         tc_d;
  logic         run_s;
  logic         pre_clr_s;
  logic         tick_s;

  assign run_s     = (state_q == ST_RUN);
  assign pre_clr_s = load_i | (stop_i & run_s) | (start_i & ~run_s);

  tick_prescaler #(
    .PW (PW)
  ) u_prescaler (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (pre_clr_s),
    .en_i       (run_s),
    .prescale_i (prescale_i),
    .tick_o     (tick_s)
  );

  // Next-state, counter and terminal-count decode in priority order.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (load_i) begin
      count_d  = load_value_i;
      reload_d = load_value_i;
      state_d  = ST_IDLE;
    end else if (stop_i && run_s) begin
      state_d = ST_IDLE;
    end else if (start_i && !run_s) begin
      state_d = ST_RUN;
      case (state_q)
        ST_DONE: count_d = reload_q;
        default: count_d = count_q;
      endcase
    end else if (tick_s) begin
      if (count_q != '0) begin
        count_d = count_q - {{(N-1){1'b0}}, 1'b1};
      end else begin
        tc_d = 1'b1;
        // Terminal tick: periodic mode reloads, one-shot parks in DONE at zero.
        if (auto_reload_i) begin
          count_d = reload_q;
        end else begin
          state_d = ST_DONE;
        end
      end
    end else begin
      state_d = state_q;
    end
  end

  // State, counter, reload and pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign count_o    = count_q;
  assign busy_o     = (state_q == ST_RUN);
  assign done_o     = (state_q == ST_DONE);
  assign tc_pulse_o = tc_q;

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed scenarios plus randomized traffic
// checked every cycle against a behavioural reference model.
module tb_down_timer;

  logic       clk;
  logic       reset;
  logic       load;
  logic [3:0] load_value;
  logic       start;
  logic       stop;
  logic       auto_reload;
  logic [7:0] prescale;
  logic [3:0] count_o;
  logic       busy_o;
  logic       done_o;
  logic       tc_o;

  int total = 0;
  int bad   = 0;

  // Reference model state: mode 0 idle, 1 running, 2 expired.
  int m_cnt, m_rel, m_pc, m_mode, m_tc;

  down_timer #(.N(4), .PW(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .load_i        (load),
    .load_value_i  (load_value),
    .start_i       (start),
    .stop_i        (stop),
    .auto_reload_i (auto_reload),
    .prescale_i    (prescale),
    .count_o       (count_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .tc_pulse_o    (tc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_rel = 0; m_pc = 0; m_mode = 0; m_tc = 0;
  endtask

  // One clock of timer behaviour, straight from the control rules.
  task automatic model_step();
    bit running;
    bit tick;
    if (reset) begin
      model_reset();
      return;
    end
    running = (m_mode == 1);
    tick    = running && (m_pc >= int'(prescale));
    m_tc    = 0;
    if (load) begin
      m_cnt = int'(load_value); m_rel = int'(load_value); m_mode = 0; m_pc = 0;
    end else if (running && stop) begin
      m_mode = 0; m_pc = 0;
    end else if (!running && start) begin
      if (m_mode == 2) m_cnt = m_rel;
      m_mode = 1; m_pc = 0;
    end else if (running) begin
      m_pc = tick ? 0 : m_pc + 1;
      if (tick && m_cnt > 0) m_cnt = m_cnt - 1;
      else if (tick) begin
        m_tc = 1;
        if (auto_reload) m_cnt = m_rel;
        else m_mode = 2;
      end
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    model_step();
    #1;
    check_eq("m_count", int'(count_o), m_cnt);
    check_eq("m_busy",  int'(busy_o),  (m_mode == 1) ? 1 : 0);
    check_eq("m_done",  int'(done_o),  (m_mode == 2) ? 1 : 0);
    check_eq("m_tc",    int'(tc_o),    m_tc);
  endtask

  task automatic do_load(input int v);
    load = 1'b1; load_value = 4'(v);
    tick_clk();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick_clk();
    start = 1'b0;
  endtask

  initial begin
    int last;
    int npulse;
    int n;
    load = 1'b0; load_value = 4'd0; start = 1'b0; stop = 1'b0;
    auto_reload = 1'b0; prescale = 8'd0; reset = 1'b0;
    model_reset();

    // Reset and idle defaults
    #1 reset = 1'b1;
    #3;
    check_eq("rst_count", int'(count_o), 0);
    check_eq("rst_busy",  int'(busy_o), 0);
    check_eq("rst_done",  int'(done_o), 0);
    check_eq("rst_tc",    int'(tc_o), 0);
    #17 reset = 1'b0;
    for (int i = 0; i < 3; i++) tick_clk();
    check_eq("idle_count", int'(count_o), 0);
    check_eq("idle_busy",  int'(busy_o), 0);

    // Async reset in the middle of a run
    do_load(9); do_start(); tick_clk(); tick_clk();
    check_eq("run_count", int'(count_o), 7);
    #2 reset = 1'b1; model_reset();
    #1;
    check_eq("amid_count", int'(count_o), 0);
    check_eq("amid_busy",  int'(busy_o), 0);
    #2 reset = 1'b0;

    // One-shot, load 3, prescale 0
    do_load(3); do_start();
    check_eq("os_busy", int'(busy_o), 1);
    check_eq("os_c3", int'(count_o), 3);
    tick_clk(); check_eq("os_c2", int'(count_o), 2);
    tick_clk(); check_eq("os_c1", int'(count_o), 1);
    tick_clk(); check_eq("os_c0", int'(count_o), 0);
    tick_clk();
    check_eq("os_tc", int'(tc_o), 1);
    check_eq("os_done", int'(done_o), 1);
    tick_clk();
    check_eq("os_tc_off", int'(tc_o), 0);
    check_eq("os_hold0", int'(count_o), 0);

    // Periodic, load 1, prescale 3: pulse every 8 cycles
    prescale = 8'd3; auto_reload = 1'b1;
    do_load(1); do_start();
    last = -1; npulse = 0;
    for (int i = 1; i <= 40; i++) begin
      tick_clk();
      if (tc_o) begin
        if (last >= 0) check_eq("per8_gap", i - last, 8);
        last = i; npulse++;
      end
    end
    check_eq("per8_pulses", npulse, 5);

    // Stop at 5, hold, resume
    prescale = 8'd0; auto_reload = 1'b0;
    do_load(9); do_start();
    for (int i = 0; i < 4; i++) tick_clk();
    check_eq("stop_pre", int'(count_o), 5);
    stop = 1'b1; tick_clk(); stop = 1'b0;
    for (int i = 0; i < 10; i++) tick_clk();
    check_eq("stop_hold", int'(count_o), 5);
    check_eq("stop_busy", int'(busy_o), 0);
    do_start();
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick_clk();
      if (tc_o && n == 0) n = i;
    end
    check_eq("resume_ticks", n, 6);

    // load beats stop and start while running
    do_load(9); do_start(); tick_clk();
    load = 1'b1; load_value = 4'd7; stop = 1'b1; start = 1'b1;
    tick_clk();
    load = 1'b0; stop = 1'b0; start = 1'b0;
    check_eq("pri_count", int'(count_o), 7);
    check_eq("pri_busy", int'(busy_o), 0);
    check_eq("pri_tc", int'(tc_o), 0);

    // start while running is ignored
    do_load(5); do_start(); tick_clk();
    check_eq("ign_c4", int'(count_o), 4);
    do_start();
    check_eq("ign_c3", int'(count_o), 3);

    // start from DONE reloads
    do_load(2); do_start();
    for (int i = 0; i < 30 && !done_o; i++) tick_clk();
    check_eq("dn_done", int'(done_o), 1);
    do_start();
    check_eq("dn_count", int'(count_o), 2);
    check_eq("dn_busy", int'(busy_o), 1);

    // load 0, one-shot: first tick is terminal
    do_load(0); do_start();
    tick_clk();
    check_eq("z_tc", int'(tc_o), 1);
    check_eq("z_done", int'(done_o), 1);

    // load 15 periodic: pulse every 16 cycles
    auto_reload = 1'b1;
    do_load(15); do_start();
    last = -1; npulse = 0;
    for (int i = 1; i <= 48; i++) begin
      tick_clk();
      if (tc_o) begin
        if (last >= 0) check_eq("per16_gap", i - last, 16);
        last = i; npulse++;
      end
    end
    check_eq("per16_pulses", npulse, 3);
    check_eq("per16_tc_now", int'(tc_o), 1);
    #2 reset = 1'b1; model_reset();
    #1;
    check_eq("rst_tc_clear", int'(tc_o), 0);
    #2 reset = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      load       = ($urandom_range(99) < 4);
      load_value = 4'($urandom_range(15));
      start      = ($urandom_range(99) < 12);
      stop       = ($urandom_range(99) < 5);
      if ($urandom_range(99) < 3) auto_reload = ~auto_reload;
      if ($urandom_range(99) < 4) prescale = 8'($urandom_range(3));
      tick_clk();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
Loadable N-bit down-counter/timer with a programmable tick prescaler, one-shot and periodic (auto-reload) modes. It counts from a loaded value down to zero and emits a one-cycle terminal-count pulse. It is the decrementing counterpart to the team's free-running up counter, and serves as a general timeout, delay and periodic-tick source.

Parameters:
N, 4, width of count, load_value and reload register
PW, 8, width of prescale input and internal prescaler counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
load  in  1  sync; count<=load_value, reload<=load_value, go IDLE
load_value  in  N  value captured on load
start  in  1  sync; IDLE/DONE -> RUN
stop  in  1  sync; RUN -> IDLE, count held
auto_reload  in  1  1=periodic, 0=one-shot; sampled at the terminal tick
prescale  in  PW  tick every prescale+1 RUN cycles
count  out  N  current count (registered)
busy  out  1  state==RUN
done  out  1  state==DONE (one-shot expired)
tc_pulse  out  1  one-cycle pulse per expiry (registered)

Behaviour:
- Reset values: count=0, reload=0, pre_cnt=0, state=IDLE, busy=0, done=0, tc_pulse=0. Asynchronous assertion mid-RUN clears everything immediately. On release, the block waits in IDLE.
- States: IDLE (hold), RUN (counting), DONE (one-shot expired, count=0).
- Control priority per cycle: load > stop > start > tick.
- load, any state: count, reload <= load_value; state->IDLE; pre_cnt<=0; tc_pulse<=0.
- stop in RUN: ->IDLE, count and reload held, pre_cnt<=0. stop in IDLE/DONE: no effect.
- start in IDLE: ->RUN, count unchanged, pre_cnt<=0.
- start in DONE: count<=reload, ->RUN, pre_cnt<=0.
- start in RUN: ignored; no restart, prescaler not cleared.
- Prescaler: active only in RUN.
  - tick = (pre_cnt >= prescale). On tick, pre_cnt<=0; otherwise pre_cnt+1.
  - prescale=0 gives a tick every RUN cycle. prescale is used live; lowering it below pre_cnt yields a tick next cycle.
- On tick in RUN:
  - count!=0: count<=count-1, tc_pulse<=0.
  - count==0: tc_pulse<=1. If auto_reload, count<=reload and stay in RUN. Otherwise ->DONE and count stays 0.
- tc_pulse is 0 in every cycle except the one following a terminal tick. It is never high two consecutive cycles unless reload=0, periodic and prescale=0; in that case it is high continuously, one pulse per cycle.
- Period: reload+1 ticks, i.e. (reload+1)*(prescale+1) clk cycles between tc_pulses in periodic mode.
- Arithmetic: unsigned, N-bit. Decrement never occurs at 0, so there is no wrap below 0.
- Start with count=0: the first tick is terminal.
- busy/done are combinational decodes of the state register (glitch-free, one-hot or binary).
- Latency: start -> busy at the next edge. The first decrement occurs on the first RUN cycle when prescale=0.

Decomposition:
- Shared package/include holds the state encodings ST_IDLE, ST_RUN, ST_DONE and the 2-bit state width constant.
- One natural sub-module: tick_prescaler (PW param; inputs clk, reset, clr, en, prescale; output tick). It is reusable by other timers.
- Counter, reload register and FSM stay in down_timer.

Test Plan:
- Reset/defaults: assert reset async mid-cycle -> count=0, busy=0, done=0, tc_pulse=0 immediately. Outputs stay so after release with no stimulus.
- One-shot: N=4, prescale=0, auto_reload=0, load 3, start at edge t -> busy=1 @t+1; count 2,1,0 at t+2..t+4; tc_pulse=1 and done=1 @t+5; tc_pulse=0 @t+6; count stays 0.
- Periodic with prescale: load 1, prescale=3, auto_reload=1, start -> tc_pulse every 8 cycles, exactly one cycle wide. count toggles 1->0 every 4 cycles. Run 5 periods.
- Stop/resume: load 9, prescale=0, start, stop when count=5 -> count holds 5 for 10 cycles, busy=0. start -> decrements from 5. tc_pulse occurs 6 ticks after resume.
- Priority/simultaneous: load=1 (value 7) with stop=1 and start=1 in RUN -> count=7, IDLE, tc_pulse=0. start in RUN at count=4 -> ignored, count continues 3. start in DONE after reload 2 -> count=2, RUN.
- Edge values: load 0 then start (one-shot) -> tc_pulse after 1 tick, DONE. Load 15 periodic with prescale=0 -> tc every 16 cycles, no wrap glitch. Async reset asserted while tc_pulse=1 -> pulse cleared at once.
